// File: rtl/axis_sample_source.sv
// axis_sample_source: FIFO-buffered AXI-Stream sample master, optional launch pacing via AXIS_SAMPLE_SOURCE_PACING_EN
module axis_sample_source #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int RATE_DIV   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         m_axis_data_tvalid,
    input  logic                         m_axis_data_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_data_tdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop, pace_ok;
    assign in_ready           = level != LW'(DEPTH);
    assign m_axis_data_tvalid = (level != '0) && pace_ok;
    assign m_axis_data_tdata  = mem[rd_ptr];
    assign push               = in_valid && in_ready;
    assign pop                = m_axis_data_tvalid && m_axis_data_tready;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end
`ifdef AXIS_SAMPLE_SOURCE_PACING_EN
    localparam int PW = $clog2(RATE_DIV+1);
    logic [PW-1:0] pace_cnt;
    always_ff @(posedge clk) begin
        if (rst) pace_cnt <= '0;
        else if (pop) pace_cnt <= PW'(RATE_DIV-1);
        else if (pace_cnt != '0) pace_cnt <= pace_cnt - 1'b1;
    end
    assign pace_ok = pace_cnt == '0;
`else
    // RATE_DIV is at least 1, so this is a constant 1
    assign pace_ok = RATE_DIV > 0;
`endif
endmodule

// File: tb/tb_axis_sample_source.sv
// tb_axis_sample_source: scoreboard bench for axis_sample_source
module tb_axis_sample_source;
    logic clk = 0, rst = 1, in_valid = 0, tready = 0;
    logic [15:0] in_data = 0;
    logic in_ready, tvalid, overflow;
    logic [15:0] tdata;
    logic [3:0] level;
    int checks = 0, errors = 0, cyc = 0, pops = 0;
    logic [15:0] exp_q[$];
    int hs_t[$];
`ifdef AXIS_SAMPLE_SOURCE_PACING_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 1;
`endif
    axis_sample_source #(.DATA_WIDTH(16), .DEPTH(8), .RATE_DIV(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .m_axis_data_tvalid(tvalid), .m_axis_data_tready(tready), .m_axis_data_tdata(tdata),
        .level(level), .overflow(overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    always @(negedge clk) begin
        if (!rst && tvalid && tready) begin
            checks++;
            pops++;
            hs_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h, required none", tdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (tdata !== e) begin
                    errors++;
                    $display("FAIL tdata_order: got %h, required %h", tdata, e);
                end
            end
        end
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push_word(input logic [15:0] d);
        in_valid = 1;
        in_data = d;
        tick();
        in_valid = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end
    initial begin
        int p0, guard;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        rst = 0;
        chk("post_rst_tvalid", tvalid, 0);
        chk("post_rst_in_ready", in_ready, 1);
        // single word
        tready = 1;
        push_word(16'h1234);
        chk("single_tvalid", tvalid, 1);
        chk("single_tdata", tdata, 16'h1234);
        tick();
        chk("single_empty_tvalid", tvalid, 0);
        chk("single_empty_level", level, 0);
        // backpressure
        tready = 0;
        push_word(16'hAAAA);
        push_word(16'h5555);
        for (int k = 0; k < 5; k++) begin
            chk("bp_tvalid", tvalid, 1);
            chk("bp_tdata", tdata, 16'hAAAA);
            tick();
        end
        tready = 1;
        tick();
        tick();
        tready = 0;
        chk("bp_level", level, 0);
        // full boundary
        for (int k = 0; k < 8; k++) push_word(16'(k));
        chk("full_level", level, 8);
        chk("full_in_ready", in_ready, 0);
        chk("full_no_ovf", overflow, 0);
        push_word(16'h00FF);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 8);
        tready = 1;
        tick();
        chk("unfull_in_ready", in_ready, 1);
        chk("unfull_level", level, 7);
        repeat (7) tick();
        tready = 0;
        chk("drain_level", level, 0);
        chk("drain_queue", exp_q.size(), 0);
        // wrap-around stream with random backpressure
        p0 = pops;
        guard = 0;
        for (int i = 0; i < 20 && guard < 1000; guard++) begin
            logic [3:0] lb;
            logic p, q;
            in_valid = 1;
            in_data = 16'(i);
            tready = 1'($urandom_range(0, 1));
            lb = level;
            p = in_valid && in_ready;
            q = tvalid && tready;
            tick();
            if (p) i++;
            if (p && q && lb > 0 && lb < 8) chk("simul_level", level, lb);
        end
        in_valid = 0;
        tready = 1;
        guard = 0;
        while (level != 0 && guard < 200) begin
            tick();
            guard++;
        end
        tready = 0;
        chk("stream_drained", level, 0);
        chk("stream_count", pops - p0, 20);
        // launch pacing
        for (int k = 0; k < 4; k++) push_word(16'h0100 + 16'(k));
        repeat (5) tick();
        hs_t.delete();
        tready = 1;
        repeat (4 * GAP + 2) tick();
        tready = 0;
        chk("pace_count", hs_t.size(), 4);
        if (hs_t.size() == 4)
            for (int k = 1; k < 4; k++) chk("pace_gap", hs_t[k] - hs_t[0], k * GAP);
        // mid-operation reset
        for (int k = 0; k < 5; k++) push_word(16'h0200 + 16'(k));
        chk("mid_level", level, 5);
        chk("mid_tvalid", tvalid, 1);
        chk("mid_overflow", overflow, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_level", level, 0);
        chk("mrst_tvalid", tvalid, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_in_ready", in_ready, 1);
        tready = 1;
        push_word(16'hBEEF);
        chk("beef_tdata", tdata, 16'hBEEF);
        tick();
        tick();
        tready = 0;
        chk("final_queue", exp_q.size(), 0);
        chk("final_level", level, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
